matmul_seq: RTL and testbench



---
 rtl/matmul_pkg.sv | 29 ++
 rtl/matmul.sv | 44 ++++
 rtl/matmul_seq.sv | 150 +++++++++++++++
 tb/tb_matmul_seq.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared constants, state encoding and operand byte positions for the 2x2 matmul
// sequencer and its systolic core.
package matmul_pkg;

  localparam int DATA_W       = 8;
  localparam int ACC_W        = 16;
  localparam int N_OPER_BYTES = 8;
  localparam int N_RES_BYTES  = 8;
  localparam int N_FEED_STEPS = 4;

  typedef enum logic [2:0] {
    LOAD,
    START,
    FEED,
    CAPTURE,
    DRAIN
  } state_t;

  // Operand stream order: A row-major, then B row-major
  localparam logic [2:0] IDX_A11 = 3'd0;
  localparam logic [2:0] IDX_A12 = 3'd1;
  localparam logic [2:0] IDX_A21 = 3'd2;
  localparam logic [2:0] IDX_A22 = 3'd3;
  localparam logic [2:0] IDX_B11 = 3'd4;
  localparam logic [2:0] IDX_B12 = 3'd5;
  localparam logic [2:0] IDX_B21 = 3'd6;
  localparam logic [2:0] IDX_B22 = 3'd7;

endpackage

// File: rtl/matmul.sv
// 2x2 output-stationary systolic multiply core: A rows enter from the left, B columns
// from the top, each cell forwards its operands one cycle later to its neighbours.
module matmul #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] A_cell_1,
  input  logic [DATA_W-1:0] A_cell_2,
  input  logic [DATA_W-1:0] B_cell_1,
  input  logic [DATA_W-1:0] B_cell_2,
  output logic [ACC_W-1:0]  out1,
  output logic [ACC_W-1:0]  out2,
  output logic [ACC_W-1:0]  out3,
  output logic [ACC_W-1:0]  out4
);

  logic [DATA_W-1:0] a11_fwd, b11_fwd, a21_fwd, b12_fwd;

  always_ff @(posedge clk) begin
    if (rst || start) begin
      out1    <= '0;
      out2    <= '0;
      out3    <= '0;
      out4    <= '0;
      a11_fwd <= '0;
      b11_fwd <= '0;
      a21_fwd <= '0;
      b12_fwd <= '0;
    end else begin
      out1    <= out1 + ACC_W'(A_cell_1) * ACC_W'(B_cell_1);
      out2    <= out2 + ACC_W'(a11_fwd)  * ACC_W'(B_cell_2);
      out3    <= out3 + ACC_W'(A_cell_2) * ACC_W'(b11_fwd);
      out4    <= out4 + ACC_W'(a21_fwd)  * ACC_W'(b12_fwd);
      a11_fwd <= A_cell_1;
      b11_fwd <= B_cell_1;
      a21_fwd <= A_cell_2;
      b12_fwd <= B_cell_2;
    end
  end

endmodule

// File: rtl/matmul_seq.sv
// Byte-stream sequencer for the 2x2 systolic matmul core: loads A/B, clears the core,
// plays the skewed feed schedule, captures C and streams it out low byte first.
module matmul_seq #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              mm_start,
  output logic [DATA_W-1:0] mm_a1,
  output logic [DATA_W-1:0] mm_a2,
  output logic [DATA_W-1:0] mm_b1,
  output logic [DATA_W-1:0] mm_b2,
  input  logic [ACC_W-1:0]  mm_c1,
  input  logic [ACC_W-1:0]  mm_c2,
  input  logic [ACC_W-1:0]  mm_c3,
  input  logic [ACC_W-1:0]  mm_c4
);
  import matmul_pkg::*;

  state_t            state;
  logic [2:0]        byte_cnt;
  logic [2:0]        out_cnt;
  logic [1:0]        step;
  logic [DATA_W-1:0] opnd [N_OPER_BYTES];
  logic [ACC_W-1:0]  res  [4];

  // Core inputs {a1, a2, b1, b2} for a feed step; the skew delays row/column 2 by one cycle
  function automatic logic [4*DATA_W-1:0] feed_word(input logic [1:0] s);
    logic [DATA_W-1:0] z;
    z = '0;
    case (s)
      2'd0:    feed_word = {opnd[IDX_A11], z, opnd[IDX_B11], z};
      2'd1:    feed_word = {opnd[IDX_A12], opnd[IDX_A21], opnd[IDX_B21], opnd[IDX_B12]};
      2'd2:    feed_word = {z, opnd[IDX_A22], z, opnd[IDX_B22]};
      default: feed_word = '0;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] res_byte(input logic [2:0] idx);
    logic [ACC_W-1:0] w;
    w = res[idx[2:1]];
    res_byte = idx[0] ? w[ACC_W-1:DATA_W] : w[DATA_W-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD;
      byte_cnt  <= '0;
      out_cnt   <= '0;
      step      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      mm_start  <= 1'b0;
      {mm_a1, mm_a2, mm_b1, mm_b2} <= '0;
      for (int unsigned i = 0; i < N_OPER_BYTES; i++) opnd[i] <= '0;
      for (int unsigned i = 0; i < 4; i++) res[i] <= '0;
    end else if (clear) begin
      state     <= LOAD;
      byte_cnt  <= '0;
      out_cnt   <= '0;
      step      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      mm_start  <= 1'b0;
      {mm_a1, mm_a2, mm_b1, mm_b2} <= '0;
      for (int unsigned i = 0; i < N_OPER_BYTES; i++) opnd[i] <= '0;
      for (int unsigned i = 0; i < 4; i++) res[i] <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            opnd[byte_cnt] <= in_data;
            if (byte_cnt == 3'(N_OPER_BYTES - 1)) begin
              byte_cnt <= '0;
              state    <= START;
              in_ready <= 1'b0;
              busy     <= 1'b1;
              mm_start <= 1'b1;
            end else begin
              byte_cnt <= byte_cnt + 3'd1;
            end
          end
        end
        START: begin
          mm_start <= 1'b0;
          step     <= '0;
          {mm_a1, mm_a2, mm_b1, mm_b2} <= feed_word(2'd0);
          state    <= FEED;
        end
        FEED: begin
          if (step == 2'(N_FEED_STEPS - 1)) begin
            {mm_a1, mm_a2, mm_b1, mm_b2} <= '0;
            state <= CAPTURE;
          end else begin
            step <= step + 2'd1;
            {mm_a1, mm_a2, mm_b1, mm_b2} <= feed_word(step + 2'd1);
          end
        end
        CAPTURE: begin
          // First output byte comes straight from the core since res is written on this edge
          res[0]    <= mm_c1;
          res[1]    <= mm_c2;
          res[2]    <= mm_c3;
          res[3]    <= mm_c4;
          out_cnt   <= '0;
          out_data  <= mm_c1[DATA_W-1:0];
          out_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= DRAIN;
        end
        DRAIN: begin
          if (out_ready) begin
            if (out_cnt == 3'(N_RES_BYTES - 1)) begin
              out_cnt   <= '0;
              out_valid <= 1'b0;
              out_data  <= '0;
              in_ready  <= 1'b1;
              state     <= LOAD;
            end else begin
              out_cnt  <= out_cnt + 3'd1;
              out_data <= res_byte(out_cnt + 3'd1);
            end
          end
        end
        default: begin
          state     <= LOAD;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          mm_start  <= 1'b0;
          {mm_a1, mm_a2, mm_b1, mm_b2} <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_seq.sv
// Self-checking bench for matmul_seq driving a real matmul core; expected results come
// from fixed vectors and a plain 2x2 matrix-product model.
module tb_matmul_seq;
  import matmul_pkg::*;

  typedef logic [7:0] bytes8_t [8];
  typedef struct {
    bytes8_t ops;
    bytes8_t exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, busy, mm_start;
  logic [7:0]  out_data, mm_a1, mm_a2, mm_b1, mm_b2;
  logic [15:0] mm_c1, mm_c2, mm_c3, mm_c4;
  logic        core_rst;

  int n_checks = 0;
  int n_fail = 0;

  assign core_rst = ~rst_n;

  always #5 clk = ~clk;

  matmul_seq #(.DATA_W(8), .ACC_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .mm_start(mm_start),
    .mm_a1(mm_a1), .mm_a2(mm_a2), .mm_b1(mm_b1), .mm_b2(mm_b2),
    .mm_c1(mm_c1), .mm_c2(mm_c2), .mm_c3(mm_c3), .mm_c4(mm_c4)
  );

  matmul #(.DATA_W(8), .ACC_W(16)) u_core (
    .clk(clk), .rst(core_rst), .start(mm_start),
    .A_cell_1(mm_a1), .A_cell_2(mm_a2), .B_cell_1(mm_b1), .B_cell_2(mm_b2),
    .out1(mm_c1), .out2(mm_c2), .out3(mm_c3), .out4(mm_c4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic bytes8_t model(input bytes8_t ops);
    int unsigned a [2][2];
    int unsigned b [2][2];
    int unsigned sum;
    bytes8_t r;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        a[i][j] = ops[2*i + j];
        b[i][j] = ops[4 + 2*i + j];
      end
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        sum = 0;
        for (int k = 0; k < 2; k++) sum += a[i][k] * b[k][j];
        sum = sum % 65536;
        r[2*(2*i + j)]     = 8'(sum % 256);
        r[2*(2*i + j) + 1] = 8'(sum / 256);
      end
    return r;
  endfunction

  // Offers the eight operand bytes, optionally with random idle gaps; returns just after the
  // edge that accepts the last byte.
  task automatic load_ops(input bytes8_t ops, input bit bubbles);
    int idx;
    int guard;
    bit acc;
    idx = 0;
    guard = 0;
    while (idx < 8 && guard < 200) begin
      if (bubbles && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = ops[idx];
      end
      acc = in_valid && in_ready;
      cyc();
      if (acc) idx++;
      guard++;
    end
    in_valid = 1'b0;
    if (idx < 8) begin
      n_checks++;
      n_fail++;
      $display("FAIL load_timeout: got %0d bytes accepted, required 8", idx);
    end
  endtask

  task automatic run_job(input string tag, input bytes8_t ops, input bytes8_t exp,
                         input bit bubbles, input bit hold, input int stall_at,
                         input int stall_len, input bit chk_lat);
    int n;
    int idx;
    int stalled;
    int guard;
    bit xfer;
    load_ops(ops, bubbles);
    in_valid = hold;
    in_data  = 8'hEE;
    n = 1;
    while (!out_valid && n < 40) begin
      if (chk_lat && n == 1)
        check({tag, "_start"}, {mm_start, busy, in_ready}, 3'b110);
      if (chk_lat && n == 2)
        check({tag, "_feed0"}, {mm_a1, mm_a2, mm_b1, mm_b2}, {ops[0], 8'h00, ops[4], 8'h00});
      if (chk_lat && n == 3)
        check({tag, "_feed1"}, {mm_a1, mm_a2, mm_b1, mm_b2}, {ops[1], ops[2], ops[6], ops[5]});
      cyc();
      n++;
    end
    if (chk_lat) check({tag, "_latency"}, n, 7);
    if (!out_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_valid_timeout: got out_valid 0, required 1", tag);
    end
    idx = 0;
    stalled = 0;
    guard = 0;
    while (idx < 8 && guard < 300) begin
      if (idx == stall_at && stalled < stall_len) begin
        out_ready = 1'b0;
        check($sformatf("%s_stall%0d", tag, stalled), {out_valid, out_data}, {1'b1, exp[idx]});
        stalled++;
      end else begin
        out_ready = 1'b1;
      end
      xfer = out_valid && out_ready;
      if (xfer) check($sformatf("%s_byte%0d", tag, idx), out_data, exp[idx]);
      cyc();
      if (xfer) idx++;
      guard++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    if (idx < 8) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_drain_timeout: got %0d bytes, required 8", tag, idx);
    end
    check({tag, "_back_to_load"}, {in_ready, out_valid, busy}, 3'b100);
  endtask

  initial begin
    vec_t tbl [3];
    bytes8_t ops;
    bytes8_t exp;

    tbl[0].ops = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    tbl[0].exp = '{8'h13, 8'h00, 8'h16, 8'h00, 8'h2B, 8'h00, 8'h32, 8'h00};
    tbl[1].ops = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    tbl[1].exp = '{8'h02, 8'hFC, 8'h02, 8'hFC, 8'h02, 8'hFC, 8'h02, 8'hFC};
    tbl[2].ops = '{8'd1, 8'd0, 8'd0, 8'd1, 8'd9, 8'd8, 8'd7, 8'd6};
    tbl[2].exp = '{8'd9, 8'd0, 8'd8, 8'd0, 8'd7, 8'd0, 8'd6, 8'd0};

    repeat (3) cyc();
    check("reset_flags", {in_ready, out_valid, busy, mm_start}, 4'b1000);
    check("reset_data", {out_data, mm_a1, mm_a2, mm_b1, mm_b2}, '0);
    rst_n = 1'b1;
    cyc();

    for (int i = 0; i < 3; i++)
      run_job($sformatf("vec%0d", i), tbl[i].ops, tbl[i].exp, 1'b0, 1'b0, 8, 0, i == 0);

    // Stall on the C12 high byte, then an immediate second job
    run_job("stall", tbl[0].ops, tbl[0].exp, 1'b0, 1'b0, 3, 5, 1'b0);
    run_job("b2b", tbl[1].ops, tbl[1].exp, 1'b0, 1'b0, 8, 0, 1'b0);

    // Gappy load and in_valid held high through the busy/drain phases
    run_job("hold", tbl[0].ops, tbl[0].exp, 1'b1, 1'b1, 8, 0, 1'b1);

    // Abort after five operand bytes; the byte offered with clear must not land
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i + 40);
      cyc();
    end
    clear    = 1'b1;
    in_data  = 8'h77;
    cyc();
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clear_state", {in_ready, out_valid, busy, mm_start}, 4'b1000);
    run_job("after_clear", tbl[2].ops, tbl[2].exp, 1'b0, 1'b0, 8, 0, 1'b0);

    // Asynchronous reset in the middle of the feed schedule
    load_ops(tbl[0].ops, 1'b0);
    cyc();
    cyc();
    check("pre_reset_feed1_a1", mm_a1, tbl[0].ops[1]);
    rst_n = 1'b0;
    #1;
    check("midjob_reset_flags", {in_ready, busy, out_valid, mm_start}, 4'b1000);
    check("midjob_reset_mm", {mm_a1, mm_a2, mm_b1, mm_b2}, '0);
    cyc();
    rst_n = 1'b1;
    cyc();
    run_job("after_reset", tbl[0].ops, tbl[0].exp, 1'b0, 1'b0, 8, 0, 1'b1);

    for (int j = 0; j < 8; j++) begin
      for (int k = 0; k < 8; k++) ops[k] = 8'($urandom);
      exp = model(ops);
      run_job($sformatf("rand%0d", j), ops, exp, 1'b1, 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 7)), int'($urandom_range(0, 4)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
